// File: rtl/btn_reset_conditioner.sv
// Push-button conditioner: 2-flop sync, debounce FSM, press/release pulses, stretched core reset.
// Latency DEBOUNCE_CYCLES+2 cycles from raw edge to btn_level/pulse; no backpressure, free-running.
module btn_reset_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RST_STRETCH     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic cpu_rst_n
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(RST_STRETCH + 1);

  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STRETCH_ONE  = SW'(1);
  localparam logic [SW-1:0] STRETCH_INIT = SW'(RST_STRETCH);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic            s1_q, sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic [SW-1:0]   stretch_q, stretch_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;

  // cnt_q holds the stable samples already seen; the sample taken on the
  // accepting edge is the DEBOUNCE_CYCLES-th, so IDLE/HELD accept directly when it is 1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE, PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          state_d = PRESS_WAIT;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HELD, RELEASE_WAIT: begin
        if (sync_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          state_d = RELEASE_WAIT;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding on level_q too keeps the core in reset through the release edge,
  // so the stretch counts RST_STRETCH full cycles after the btn_release cycle.
  always_comb begin
    stretch_d   = stretch_q;
    cpu_rst_n_d = cpu_rst_n_q;
    if (level_d || level_q) begin
      stretch_d   = STRETCH_INIT;
      cpu_rst_n_d = 1'b0;
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - STRETCH_ONE;
      if (stretch_q == STRETCH_ONE) begin
        cpu_rst_n_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      sync_q      <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      stretch_q   <= STRETCH_INIT;
      cpu_rst_n_q <= 1'b0;
    end else begin
      s1_q        <= btn_raw;
      sync_q      <= s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      stretch_q   <= stretch_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign cpu_rst_n   = cpu_rst_n_q;

endmodule

// File: tb/tb_btn_reset_conditioner.sv
// Bench for btn_reset_conditioner: directed scenarios plus randomized run against a run-length model.
module tb_btn_reset_conditioner;

  localparam int DB_A = 4;
  localparam int DB_B = 1;
  localparam int RS   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic lvl_a, prs_a, rel_a, crn_a;
  logic lvl_b, prs_b, rel_b, crn_b;
  logic [3:0] dut_a, dut_b;

  int tests_run    = 0;
  int tests_failed = 0;

  btn_reset_conditioner #(.DEBOUNCE_CYCLES(DB_A), .RST_STRETCH(RS)) u_a (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_a),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .cpu_rst_n(crn_a)
  );

  btn_reset_conditioner #(.DEBOUNCE_CYCLES(DB_B), .RST_STRETCH(RS)) u_b (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_b),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .cpu_rst_n(crn_b)
  );

  assign dut_a = {lvl_a, prs_a, rel_a, crn_a};
  assign dut_b = {lvl_b, prs_b, rel_b, crn_b};

  initial forever #20 clk = ~clk;

  // Reference: sync = raw delayed two samples; accepted level flips after
  // db consecutive samples that disagree with it; reset stretch as plain integer.
  typedef struct packed {
    logic s1;
    logic s2;
    logic lvl;
    logic press;
    logic rel;
    logic crn;
    int   run;
    int   cnt;
  } mstate_t;

  mstate_t m_a, m_b;

  function automatic mstate_t model_next(mstate_t m, logic raw, logic rst, int db);
    mstate_t n;
    n = m;
    if (!rst) begin
      n     = '0;
      n.cnt = RS;
      return n;
    end
    n.s1    = raw;
    n.s2    = m.s1;
    n.press = 1'b0;
    n.rel   = 1'b0;
    if (m.s2 != m.lvl) begin
      n.run = m.run + 1;
      if (n.run == db) begin
        n.lvl   = m.s2;
        n.press = m.s2;
        n.rel   = ~m.s2;
        n.run   = 0;
      end
    end else begin
      n.run = 0;
    end
    if (n.lvl || m.lvl) begin
      n.cnt = RS;
      n.crn = 1'b0;
    end else if (m.cnt > 0) begin
      n.cnt = m.cnt - 1;
      if (n.cnt == 0) n.crn = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_vec(mstate_t m);
    return {m.lvl, m.press, m.rel, m.crn};
  endfunction

  always @(posedge clk) begin
    m_a <= model_next(m_a, raw_a, rst_n, DB_A);
    m_b <= model_next(m_b, raw_b, rst_n, DB_B);
  end

  task automatic test_reset();
    logic e;
    rst_n = 1'b0;
    raw_a = 1'b0;
    raw_b = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if ({dut_a, dut_b} !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_values: got a=%b b=%b expected 0000 0000", dut_a, dut_b);
      end
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      e = (j >= RS);
      tests_run++;
      if (dut_a !== {3'b000, e} || dut_b !== {3'b000, e}) begin
        tests_failed++;
        $display("FAIL powerup_stretch edge %0d: got a=%b b=%b expected %b", j, dut_a, dut_b, {3'b000, e});
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] e;
    raw_a = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      e = {(j >= 5), (j == 5), 1'b0, (j < 5)};
      tests_run++;
      if (dut_a !== e) begin
        tests_failed++;
        $display("FAIL clean_press edge k+%0d: got %b expected %b", j, dut_a, e);
      end
      tests_run++;
      if (dut_a !== exp_vec(m_a)) begin
        tests_failed++;
        $display("FAIL clean_press_model edge k+%0d: got %b expected %b", j, dut_a, exp_vec(m_a));
      end
    end
  endtask

  task automatic test_release_stretch();
    logic [3:0] e;
    raw_a = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      e = {(j < 5), 1'b0, (j == 5), (j >= 8)};
      tests_run++;
      if (dut_a !== e) begin
        tests_failed++;
        $display("FAIL release_stretch edge k+%0d: got %b expected %b", j, dut_a, e);
      end
    end
  endtask

  task automatic test_bounce();
    logic [12:0] pat;
    pat = 13'b1110111000000;
    for (int j = 12; j >= 0; j--) begin
      raw_a = pat[j];
      @(negedge clk);
      tests_run++;
      if (dut_a !== 4'b0001) begin
        tests_failed++;
        $display("FAIL bounce_reject step %0d: got %b expected 0001", 12 - j, dut_a);
      end
    end
  endtask

  // DEBOUNCE_CYCLES=1 instance: release then press on the very next edge,
  // so the second press lands inside the stretch window and must reload it.
  task automatic test_repress_stretch();
    logic [3:0] e;
    logic       l, p, r, c;
    for (int j = 0; j < 17; j++) begin
      raw_b = (j < 4) || (j >= 5 && j < 10);
      @(negedge clk);
      l = (j >= 2 && j < 6) || (j >= 7 && j < 12);
      p = (j == 2) || (j == 7);
      r = (j == 6) || (j == 12);
      c = (j < 2) || (j >= 15);
      e = {l, p, r, c};
      tests_run++;
      if (dut_b !== e) begin
        tests_failed++;
        $display("FAIL repress_stretch edge %0d: got %b expected %b", j, dut_b, e);
      end
      tests_run++;
      if (dut_b !== exp_vec(m_b)) begin
        tests_failed++;
        $display("FAIL repress_model edge %0d: got %b expected %b", j, dut_b, exp_vec(m_b));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    raw_a = 1'b1;
    for (int j = 0; j < 14; j++) begin
      if (j == 4) rst_n = 1'b0;
      if (j == 6) rst_n = 1'b1;
      @(negedge clk);
      if (j < 4)      e = 4'b0001;
      else if (j < 6) e = 4'b0000;
      else            e = {(j >= 11), (j == 11), 1'b0, (j >= 8 && j < 11)};
      tests_run++;
      if (dut_a !== e) begin
        tests_failed++;
        $display("FAIL reset_mid edge %0d: got %b expected %b", j, dut_a, e);
      end
    end
    raw_a = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      tests_run++;
      if (dut_a !== exp_vec(m_a)) begin
        tests_failed++;
        $display("FAIL reset_mid_recover cycle %0d: got %b expected %b", j, dut_a, exp_vec(m_a));
      end
    end
  endtask

  task automatic test_random();
    int hold_a, hold_b, rst_left;
    hold_a   = 0;
    hold_b   = 0;
    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_a == 0) begin
        raw_a  = 1'($urandom_range(0, 1));
        hold_a = int'($urandom_range(1, 8));
      end
      hold_a--;
      if (hold_b == 0) begin
        raw_b  = 1'($urandom_range(0, 1));
        hold_b = int'($urandom_range(1, 4));
      end
      hold_b--;
      if (rst_left > 0) begin
        rst_n = 1'b0;
        rst_left--;
      end else begin
        rst_n = 1'b1;
        if ($urandom_range(0, 399) == 0) rst_left = int'($urandom_range(1, 3));
      end
      @(negedge clk);
      tests_run++;
      if (dut_a !== exp_vec(m_a) || dut_b !== exp_vec(m_b)) begin
        tests_failed++;
        $display("FAIL random cycle %0d: got a=%b b=%b expected a=%b b=%b",
                 c, dut_a, dut_b, exp_vec(m_a), exp_vec(m_b));
      end
      tests_run++;
      if ((prs_a && rel_a) || (prs_b && rel_b)) begin
        tests_failed++;
        $display("FAIL pulse_exclusive cycle %0d: got a=%b b=%b expected press and release not both set",
                 c, dut_a, dut_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release_stretch();
    test_bounce();
    test_repress_stretch();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
